// File: rtl/result_bcd_fsm_pkg.sv
// Shared definitions for the result-to-BCD display path.
//   - One-hot ALU_OP codes of the finished calculation.
//   - FSM state encoding (2 bits).
//   - Leading-zero blanking helper for the five-digit display.
package result_bcd_fsm_pkg;

    localparam logic [7:0] OP_ADD = 8'h01;
    localparam logic [7:0] OP_SUB = 8'h02;
    localparam logic [7:0] OP_AND = 8'h04;
    localparam logic [7:0] OP_CMP = 8'h08;
    localparam logic [7:0] OP_OR  = 8'h10;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PREP  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // digs = {dig4, dig3, dig2, dig1, dig0}. A digit is blank while it and
    // every higher digit are zero; the units digit is always shown.
    function automatic logic [4:0] lead_blank(input logic [19:0] digs);
        logic [4:0] b;
        b    = '0;
        b[4] = (digs[19:16] == 4'd0);
        b[3] = b[4] && (digs[15:12] == 4'd0);
        b[2] = b[3] && (digs[11:8]  == 4'd0);
        b[1] = b[2] && (digs[7:4]   == 4'd0);
        b[0] = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/result_bcd_fsm_if.sv
// Handshake and result bus between the calculator core and the BCD converter.
//   master : drives start, RESH, RESL, ALU_OP; receives converter outputs
//   slave  : the converter (result_bcd_fsm)
interface result_bcd_fsm_if;

    logic       start;
    logic [7:0] RESH;
    logic [7:0] RESL;
    logic [7:0] ALU_OP;
    logic       busy;
    logic       done;
    logic       neg;
    logic [3:0] dig0;
    logic [3:0] dig1;
    logic [3:0] dig2;
    logic [3:0] dig3;
    logic [3:0] dig4;
    logic [4:0] blank;

    modport master (
        output start, RESH, RESL, ALU_OP,
        input  busy, done, neg, dig0, dig1, dig2, dig3, dig4, blank
    );

    modport slave (
        input  start, RESH, RESL, ALU_OP,
        output busy, done, neg, dig0, dig1, dig2, dig3, dig4, blank
    );

endinterface

// File: rtl/result_bcd_fsm_bcd_dabble_step.sv
// One double-dabble iteration: every BCD nibble >= 5 gets +3, then the
// whole {BCD, binary} register shifts left by one bit.
//   din  : current shift register {DIGITS BCD nibbles, WIDTH binary bits}
//   dout : register after correction and shift
module bcd_dabble_step #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic [DIGITS*4+WIDTH-1:0] din,
    output logic [DIGITS*4+WIDTH-1:0] dout
);

    logic [DIGITS*4+WIDTH-1:0] adj;

    always_comb begin
        adj = din;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (adj[WIDTH+4*i +: 4] >= 4'd5) begin
                adj[WIDTH+4*i +: 4] = adj[WIDTH+4*i +: 4] + 4'd3;
            end
        end
        dout = adj << 1;
    end

endmodule

// File: rtl/result_bcd_fsm.sv
// Converts the 16-bit ALU result RESH:RESL into five BCD digits for the
// 7-segment display. Subtraction results are shown as sign + magnitude.
//   clk    : system clock, rising edge
//   reset  : synchronous, active-low
//   bus    : slave side of result_bcd_fsm_if
//            start/RESH/RESL/ALU_OP in; busy/done/neg/dig0..dig4/blank out
// start in IDLE is captured at edge E; done pulses (and outputs update)
// at edge E+18. busy covers the 18 cycles in between.
module result_bcd_fsm
    import result_bcd_fsm_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5,
    parameter logic [7:0]  SUB_OP = 8'h02
) (
    input  logic             clk,
    input  logic             reset,
    result_bcd_fsm_if.slave  bus
);

    localparam int unsigned SR_W     = DIGITS*4 + WIDTH;
    localparam logic [3:0]  CNT_LAST = 4'(WIDTH - 1);

    logic [1:0]       state;
    logic [3:0]       cnt;
    logic [WIDTH-1:0] res_q;
    logic [7:0]       op_q;
    logic             neg_n;
    logic [SR_W-1:0]  sh;
    logic [SR_W-1:0]  sh_next;

    logic             busy_q;
    logic             done_q;
    logic             neg_q;
    logic [19:0]      digs_q;
    logic [4:0]       blank_q;

    logic             is_neg;
    logic [WIDTH-1:0] mag;
    logic [19:0]      digs_new;

    bcd_dabble_step #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_step (
        .din  (sh),
        .dout (sh_next)
    );

    // 0x8000 negates to itself, which is the correct unsigned magnitude 32768.
    always_comb begin
        is_neg   = (op_q == SUB_OP) && res_q[WIDTH-1];
        mag      = is_neg ? (~res_q + {{(WIDTH-1){1'b0}}, 1'b1}) : res_q;
        digs_new = sh[WIDTH +: 20];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            res_q   <= '0;
            op_q    <= '0;
            neg_n   <= 1'b0;
            sh      <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            neg_q   <= 1'b0;
            digs_q  <= '0;
            blank_q <= 5'b11110;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        res_q  <= {bus.RESH, bus.RESL};
                        op_q   <= bus.ALU_OP;
                        busy_q <= 1'b1;
                        state  <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    neg_n <= is_neg;
                    sh    <= {{(DIGITS*4){1'b0}}, mag};
                    cnt   <= '0;
                    state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    sh  <= sh_next;
                    cnt <= cnt + 4'd1;
                    if (cnt == CNT_LAST) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    digs_q  <= digs_new;
                    blank_q <= lead_blank(digs_new);
                    neg_q   <= neg_n;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.neg   = neg_q;
    assign bus.dig0  = digs_q[3:0];
    assign bus.dig1  = digs_q[7:4];
    assign bus.dig2  = digs_q[11:8];
    assign bus.dig3  = digs_q[15:12];
    assign bus.dig4  = digs_q[19:16];
    assign bus.blank = blank_q;

endmodule

// File: tb/tb_result_bcd_fsm.sv
// Directed bench for result_bcd_fsm: hand-computed digit/sign/blank vectors,
// 18-cycle latency, busy window, ignored start while busy, back-to-back start
// on the done cycle, and reset mid-conversion.
module tb_result_bcd_fsm;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    int   cyc;
    int   bcyc;
    int   dones;

    result_bcd_fsm_if bus();

    result_bcd_fsm #(
        .WIDTH  (16),
        .DIGITS (5),
        .SUB_OP (8'h02)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a start for one edge, then scramble the data inputs so that
    // only the captured values can produce the right answer.
    task automatic issue(input logic [15:0] res, input logic [7:0] op);
        bus.start  = 1'b1;
        bus.RESH   = res[15:8];
        bus.RESL   = res[7:0];
        bus.ALU_OP = op;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.RESH   = 8'hA5;
        bus.RESL   = 8'h5A;
        bus.ALU_OP = 8'h80;
    endtask

    // Count edges until done, and cycles during which busy was high.
    task automatic wait_done(output int c, output int b);
        c = 0;
        b = 0;
        while (!bus.done && c < 40) begin
            if (bus.busy) b++;
            @(posedge clk); #1;
            c++;
        end
    endtask

    task automatic chk_out(input string tag, input logic [19:0] digs,
                           input logic n, input logic [4:0] bl);
        chk({tag, "_digits"}, {12'd0, bus.dig4, bus.dig3, bus.dig2, bus.dig1, bus.dig0}, {12'd0, digs});
        chk({tag, "_neg"},    {31'd0, bus.neg}, {31'd0, n});
        chk({tag, "_blank"},  {27'd0, bus.blank}, {27'd0, bl});
    endtask

    task automatic convert(input string tag, input logic [15:0] res, input logic [7:0] op,
                           input logic [19:0] digs, input logic n, input logic [4:0] bl);
        issue(res, op);
        wait_done(cyc, bcyc);
        chk({tag, "_latency"}, cyc, 32'd18);
        chk({tag, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
        chk_out(tag, digs, n, bl);
        @(posedge clk); #1;
        chk({tag, "_done_one_cycle"}, {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        reset      = 1'b0;
        bus.start  = 1'b0;
        bus.RESH   = 8'h00;
        bus.RESL   = 8'h00;
        bus.ALU_OP = 8'h01;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk_out("rst", 20'h00000, 1'b0, 5'b11110);
        reset = 1'b1;
        @(posedge clk); #1;

        // 1: zero, ADD
        convert("zero_add", 16'h0000, 8'h01, 20'h00000, 1'b0, 5'b11110);

        // 2: 1000, ADD, busy window exactly 18 cycles
        issue(16'h03E8, 8'h01);
        wait_done(cyc, bcyc);
        chk("k1000_latency", cyc, 32'd18);
        chk("k1000_busy_cycles", bcyc, 32'd18);
        chk_out("k1000", 20'h01000, 1'b0, 5'b10000);

        // 3: 0xFFFF as unsigned and as signed -1
        @(posedge clk); #1;
        convert("ffff_or",  16'hFFFF, 8'h10, 20'h65535, 1'b0, 5'b00000);
        convert("ffff_sub", 16'hFFFF, 8'h02, 20'h00001, 1'b1, 5'b11110);

        // 4: most negative, then signed zero
        convert("m8000_sub", 16'h8000, 8'h02, 20'h32768, 1'b1, 5'b00000);
        convert("zero_sub",  16'h0000, 8'h02, 20'h00000, 1'b0, 5'b11110);

        // Extra patterns: CMP 66, SUB -100
        convert("k66_cmp",  16'h0042, 8'h08, 20'h00066, 1'b0, 5'b11100);
        convert("m100_sub", 16'hFF9C, 8'h02, 20'h00100, 1'b1, 5'b11000);

        // 5: second start at E+5 is ignored
        issue(16'h3039, 8'h01);
        repeat (4) begin
            @(posedge clk); #1;
        end
        bus.start = 1'b1;
        bus.RESH  = 8'h00;
        bus.RESL  = 8'h07;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(cyc, bcyc);
        chk("ignore_latency", cyc, 32'd13);
        chk_out("ignore", 20'h12345, 1'b0, 5'b00000);
        // start on the done cycle is accepted
        issue(16'h0929, 8'h04);
        wait_done(cyc, bcyc);
        chk("b2b_latency", cyc, 32'd18);
        chk_out("b2b", 20'h02345, 1'b0, 5'b10000);
        @(posedge clk); #1;

        // 6: reset at E+10 mid-conversion
        issue(16'h1234, 8'h01);
        repeat (9) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
        @(posedge clk); #1;
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst_done", {31'd0, bus.done}, 32'd0);
        chk_out("midrst", 20'h00000, 1'b0, 5'b11110);
        reset = 1'b1;
        dones = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        chk("midrst_no_done", dones, 32'd0);
        chk("midrst_idle_busy", {31'd0, bus.busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
